uart_frame_ctrl: RTL

Parametrised framing controller between the UART byte interface and the edge-detection pipeline. It replaces the raw pin-driven kernel select with an in-band packet header. It parses a header, forwards exactly WIDTH×HEIGHT pixels into the pipeline, and buffers processed pixels toward the UART TX path with backpressure. It closes every frame with a status byte.

---
 rtl/uart_frame_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses an in-band header from the UART RX byte stream and forwards exactly W*H pixels.
// Processed pixels are queued toward UART TX, and every frame is closed with a status byte.
// Latency: rx->pix_out is 1 cycle; FIFO head->tx is 1 cycle; tx_full holds pops and the trailer; a full FIFO drops pushes.
module uart_frame_ctrl #(
  parameter int          DATA_W      = 8,
  parameter int          DIM_W       = 12,
  parameter int          MAX_DIM     = 1024,
  parameter int          NUM_KERNELS = 4,
  parameter int          OUT_DEPTH   = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  OK_BYTE     = 8'h5A,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE,
  localparam int         KSEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_out_valid,
  output logic [KSEL_W-1:0] kernel_sel,
  output logic [DIM_W-1:0]  img_width,
  output logic [DIM_W-1:0]  img_height,
  output logic              frame_start,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_full,
  output logic              busy,
  output logic              overflow
);

  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STREAM, S_DRAIN, S_TRAIL} state_t;

  state_t              state_q;
  logic [2:0]          hdr_idx_q;
  logic [KSEL_W-1:0]   mode_q;
  logic [7:0]          wlo_q, whi_q, hlo_q;
  logic [KSEL_W-1:0]   kernel_sel_q;
  logic [DIM_W-1:0]    img_width_q, img_height_q;
  logic [CNT_W-1:0]    area_q, in_cnt_q, out_cnt_q;
  logic                frame_start_q;
  logic [DATA_W-1:0]   pix_out_q;
  logic                pix_vld_q;
  logic                trail_err_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem_q [OUT_DEPTH];
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_wr_q;

  logic [DIM_W-1:0]    hdr_w, hdr_h;
  logic                hdr_ok;
  logic [CNT_W-1:0]    hdr_area;
  logic [CNT_W-1:0]    in_cnt_inc;
  logic                fifo_empty, fifo_full;
  logic                push, pop, trail_fire;

  // Header validation: H_HI is the byte currently on rx_data, the other fields are already stored.
  always_comb begin
    hdr_w  = DIM_W'({whi_q, wlo_q});
    hdr_h  = DIM_W'({rx_data[7:0], hlo_q});
    hdr_ok = (32'(mode_q) < 32'(NUM_KERNELS)) &&
             (hdr_w != '0) && (32'(hdr_w) <= 32'(MAX_DIM)) &&
             (hdr_h != '0) && (32'(hdr_h) <= 32'(MAX_DIM));
  end

  assign hdr_area   = CNT_W'(hdr_w) * CNT_W'(hdr_h);
  assign in_cnt_inc = in_cnt_q + 1'b1;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = proc_valid && !fifo_full;
  assign pop        = !fifo_empty && !tx_full;
  // The trailer only goes out once every queued pixel has been sent.
  assign trail_fire = (state_q == S_TRAIL) && fifo_empty && !tx_full;

  // Frame sequencer: header parse, pixel forwarding, drain wait, trailer hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hdr_idx_q     <= '0;
      mode_q        <= '0;
      wlo_q         <= '0;
      whi_q         <= '0;
      hlo_q         <= '0;
      kernel_sel_q  <= '0;
      img_width_q   <= '0;
      img_height_q  <= '0;
      area_q        <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      pix_out_q     <= '0;
      pix_vld_q     <= 1'b0;
      trail_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      pix_vld_q     <= 1'b0;
      if (proc_valid) begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (rx_valid && (rx_data[7:0] == SYNC_BYTE)) begin
            state_q   <= S_HDR;
            hdr_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            case (hdr_idx_q)
              3'd0:    mode_q <= rx_data[KSEL_W-1:0];
              3'd1:    wlo_q  <= rx_data[7:0];
              3'd2:    whi_q  <= rx_data[7:0];
              3'd3:    hlo_q  <= rx_data[7:0];
              default: ;
            endcase
            if (hdr_idx_q == 3'd4) begin
              if (hdr_ok) begin
                kernel_sel_q  <= mode_q;
                img_width_q   <= hdr_w;
                img_height_q  <= hdr_h;
                area_q        <= hdr_area;
                in_cnt_q      <= '0;
                out_cnt_q     <= proc_valid ? CNT_W'(1) : '0;
                frame_start_q <= 1'b1;
                trail_err_q   <= 1'b0;
                state_q       <= S_STREAM;
              end else begin
                trail_err_q   <= 1'b1;
                state_q       <= S_TRAIL;
              end
            end else begin
              hdr_idx_q <= hdr_idx_q + 3'd1;
            end
          end
        end
        S_STREAM: begin
          // SYNC bytes are plain pixel data here.
          if (rx_valid) begin
            pix_out_q <= rx_data;
            pix_vld_q <= 1'b1;
            in_cnt_q  <= in_cnt_inc;
            if (in_cnt_inc == area_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // RX bytes are dropped; wait for every processed pixel to leave the FIFO.
          if ((out_cnt_q >= area_q) && fifo_empty) begin
            state_q <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (trail_fire) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO pointers and sticky overflow; a push into a full FIFO is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (proc_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= proc_data;
    end
  end

  // TX byte register: a FIFO pop or the trailer, never both in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_wr_q <= 1'b0;
      if (pop) begin
        tx_wr_q   <= 1'b1;
        tx_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end else if (trail_fire) begin
        tx_wr_q   <= 1'b1;
        tx_data_q <= trail_err_q ? DATA_W'(ERR_BYTE) : DATA_W'(OK_BYTE);
      end
    end
  end

  assign pix_out       = pix_out_q;
  assign pix_out_valid = pix_vld_q;
  assign kernel_sel    = kernel_sel_q;
  assign img_width     = img_width_q;
  assign img_height    = img_height_q;
  assign frame_start   = frame_start_q;
  assign tx_data       = tx_data_q;
  assign tx_wr         = tx_wr_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;

endmodule
